// File: rtl/hazard_unit.sv
// hazard_unit: scoreboard-based RAW hazard detection, operand forwarding select, stall/flush control.
// Define HAZARD_FWD_EN for forwarding; without it every in-flight match stalls until the writer retires.
module hazard_unit #(
  parameter int AW = 5,
  parameter int DEPTH = 3,
  parameter int CNT_W = 32,
  localparam int FW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs1_addr,
  input  logic             id_rs1_use,
  input  logic [AW-1:0]    id_rs2_addr,
  input  logic             id_rs2_use,
  input  logic [AW-1:0]    id_rd_addr,
  input  logic             id_rf_wen,
  input  logic             id_is_load,
  input  logic             ex_jump_flag,
  output logic             stall,
  output logic             flush,
  output logic [FW-1:0]    fwd_rs1,
  output logic [FW-1:0]    fwd_rs2,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  logic [DEPTH:1] v_q, v_d, ld_q, ld_d;
  logic [AW-1:0] rd_q [DEPTH:1];
  logic [AW-1:0] rd_d [DEPTH:1];
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic [FW-1:0] m1, m2;
  logic l1, l2, haz, active, issue;
  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    m1 = '0;
    m2 = '0;
    l1 = 1'b0;
    l2 = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (id_rs1_use && id_rs1_addr != '0 && v_q[k] && rd_q[k] == id_rs1_addr) begin
        m1 = FW'(k);
        l1 = ld_q[k];
      end
      if (id_rs2_use && id_rs2_addr != '0 && v_q[k] && rd_q[k] == id_rs2_addr) begin
        m2 = FW'(k);
        l2 = ld_q[k];
      end
    end
  end
  assign active = reset && id_valid && !ex_jump_flag;
`ifdef HAZARD_FWD_EN
  assign haz = (m1 == FW'(1) && l1) || (m2 == FW'(1) && l2);
  assign fwd_rs1 = (active && !haz) ? m1 : '0;
  assign fwd_rs2 = (active && !haz) ? m2 : '0;
`else
  assign haz = (m1 != '0) || (m2 != '0);
  assign fwd_rs1 = '0;
  assign fwd_rs2 = '0;
`endif
  assign stall = active && haz;
  assign flush = reset && ex_jump_flag;
  assign issue = id_valid && !stall && !flush;
  always_comb begin
    v_d = {v_q[DEPTH-1:1], issue && id_rf_wen};
    ld_d = {ld_q[DEPTH-1:1], issue && id_is_load};
    rd_d[1] = id_rd_addr;
    for (int k = 2; k <= DEPTH; k++) rd_d[k] = rd_q[k-1];
    stall_cnt_d = stall_cnt_q + CNT_W'(stall && !(&stall_cnt_q));
    flush_cnt_d = flush_cnt_q + CNT_W'(flush && !(&flush_cnt_q));
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      v_q <= '0;
      ld_q <= '0;
      for (int k = 1; k <= DEPTH; k++) rd_q[k] <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      v_q <= v_d;
      ld_q <= ld_d;
      for (int k = 1; k <= DEPTH; k++) rd_q[k] <= rd_d[k];
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed vectors for hazard_unit, expectations follow HAZARD_FWD_EN.
module tb_hazard_unit;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, id_valid, id_rs1_use, id_rs2_use, id_rf_wen, id_is_load, ex_jump_flag;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic stall, flush;
  logic [1:0] fwd_rs1, fwd_rs2;
  logic [31:0] stall_cnt, flush_cnt;
  int total = 0, bad = 0, exp_stall = 0;
  hazard_unit dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs1_use(id_rs1_use),
    .id_rs2_addr(id_rs2_addr), .id_rs2_use(id_rs2_use),
    .id_rd_addr(id_rd_addr), .id_rf_wen(id_rf_wen), .id_is_load(id_is_load),
    .ex_jump_flag(ex_jump_flag), .stall(stall), .flush(flush),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                       input logic u2, input logic [4:0] rd, input logic wen, input logic ld, input logic j);
    id_valid = v;
    id_rs1_addr = r1;
    id_rs1_use = u1;
    id_rs2_addr = r2;
    id_rs2_use = u2;
    id_rd_addr = rd;
    id_rf_wen = wen;
    id_is_load = ld;
    ex_jump_flag = j;
    #1;
  endtask
  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic hold(input string tag, input int ns, input int f1, input int f2);
    for (int i = 0; i <= ns; i++) begin
      chk({tag, "_stall"}, stall, i < ns);
      chk({tag, "_fwd1"}, fwd_rs1, (i == ns) ? f1 : 0);
      chk({tag, "_fwd2"}, fwd_rs2, (i == ns) ? f2 : 0);
      tick();
    end
    exp_stall += ns;
  endtask
  initial begin
    reset = 1'b0;
    drive(1, 3, 1, 0, 0, 3, 1, 1, 1);
    tick();
    tick();
    chk("rst_flush", flush, 0);
    chk("rst_stall", stall, 0);
    chk("rst_scnt", stall_cnt, 0);
    chk("rst_fcnt", flush_cnt, 0);
    reset = 1'b1;
    idle(1);
    chk("rst_fcnt_after", flush_cnt, 0);
    // ADD x5 then read x5
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
    chk("add_issue_stall", stall, 0);
    tick();
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
    hold("add_use", FWD ? 0 : 3, FWD ? 1 : 0, 0);
    idle(3);
    chk("add_scnt", stall_cnt, exp_stall);
    // LW x6 then read rs2=x6
    drive(1, 0, 0, 0, 0, 6, 1, 1, 0);
    tick();
    drive(1, 0, 0, 6, 1, 0, 0, 0, 0);
    hold("lw_use", FWD ? 1 : 3, 0, FWD ? 2 : 0);
    idle(3);
    chk("lw_scnt", stall_cnt, exp_stall);
    // Two in-flight x7 writers; youngest wins
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0);
    tick();
    tick();
    drive(1, 7, 1, 0, 0, 0, 0, 0, 0);
    hold("x7_young", FWD ? 0 : 3, FWD ? 1 : 0, 0);
    idle(3);
    // x0 writer never matches
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    drive(1, 0, 1, 0, 1, 0, 0, 0, 0);
    chk("x0_stall", stall, 0);
    chk("x0_fwd1", fwd_rs1, 0);
    chk("x0_fwd2", fwd_rs2, 0);
    idle(3);
    chk("x0_scnt", stall_cnt, exp_stall);
    // Jump coincides with load-use; the squashed LW x9 must not enter the scoreboard
    drive(1, 0, 0, 0, 0, 6, 1, 1, 0);
    tick();
    drive(1, 0, 0, 6, 1, 9, 1, 1, 1);
    chk("jmp_flush", flush, 1);
    chk("jmp_stall", stall, 0);
    chk("jmp_fwd2", fwd_rs2, 0);
    tick();
    drive(1, 9, 1, 0, 0, 0, 0, 0, 0);
    chk("jmp_bubble_stall", stall, 0);
    chk("jmp_bubble_fwd1", fwd_rs1, 0);
    chk("jmp_flush_off", flush, 0);
    chk("jmp_fcnt", flush_cnt, 1);
    chk("jmp_scnt", stall_cnt, exp_stall);
    idle(3);
    // Reset with three writers in flight
    for (int i = 10; i < 13; i++) begin
      drive(1, 0, 0, 0, 0, 5'(i), 1, 0, 0);
      tick();
    end
    drive(1, 10, 1, 11, 1, 0, 0, 0, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_flush", flush, 0);
    chk("mid_rst_fwd1", fwd_rs1, 0);
    tick();
    reset = 1'b1;
    drive(1, 10, 1, 11, 1, 0, 0, 0, 0);
    chk("post_rst_stall", stall, 0);
    chk("post_rst_fwd1", fwd_rs1, 0);
    chk("post_rst_fwd2", fwd_rs2, 0);
    chk("post_rst_scnt", stall_cnt, 0);
    chk("post_rst_fcnt", flush_cnt, 0);
    drive(1, 12, 1, 0, 0, 0, 0, 0, 0);
    chk("post_rst_x12", stall, 0);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
